// File: rtl/beat_burst_arbiter_pkg.sv
// Shared types and defaults for the two-port burst arbiter.
package beat_burst_arbiter_pkg;

  localparam int BEATS_DEF  = 8;
  localparam int DATA_W_DEF = 64;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Beat at the default data width. The top builds the same layout at its own DATA_W.
  typedef struct packed {
    logic                  id;
    logic [2:0]            offset;
    logic [DATA_W_DEF-1:0] data;
  } beat_t;

  // Choose the port to present ready on next.
  // If both ports request, rr breaks the tie.
  // If neither port requests, the current choice is kept.
  function automatic logic pick_port(input logic v0, input logic v1,
                                     input logic rr, input logic cur);
    if (v0 && v1) return rr;
    if (v0)       return 1'b0;
    if (v1)       return 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/beat_out_slice.sv
// Single-entry valid/ready output register for one beat plus its source index.
module beat_out_slice #(
  parameter int W = 68
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_src,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_src,
  output logic         slot_free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         src_q, src_d;

  assign slot_free = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

  // Load on an accepted beat; drop valid once downstream has taken the beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (in_valid) begin
      valid_d = 1'b1;
      data_d  = in_data;
      src_d   = in_src;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: rtl/beat_burst_arbiter.sv
// Two-port burst arbiter: a grant is held for a whole burst of BEATS beats.
// The output is a one-entry register.
//
// state     | meaning
// ST_IDLE   | between bursts; the registered grant gnt_q follows the requesters, and rr breaks ties
// ST_LOCKED | mid-burst; only lock_q is served until its last beat is accepted
module beat_burst_arbiter
  import beat_burst_arbiter_pkg::*;
#(
  parameter int BEATS  = BEATS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_0_valid,
  output logic              io_in_0_ready,
  input  logic              io_in_0_bits_id,
  input  logic [2:0]        io_in_0_bits_offset,
  input  logic [DATA_W-1:0] io_in_0_bits_data,
  input  logic              io_in_1_valid,
  output logic              io_in_1_ready,
  input  logic              io_in_1_bits_id,
  input  logic [2:0]        io_in_1_bits_offset,
  input  logic [DATA_W-1:0] io_in_1_bits_data,
  input  logic              io_out_ready,
  output logic              io_out_valid,
  output logic              io_out_bits_id,
  output logic [2:0]        io_out_bits_offset,
  output logic [DATA_W-1:0] io_out_bits_data,
  output logic              io_out_bits_src,
  output logic              io_err_offset
);

  typedef struct packed {
    logic              id;
    logic [2:0]        offset;
    logic [DATA_W-1:0] data;
  } beat_w_t;

  localparam int BEAT_W = $bits(beat_w_t);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic             lock_q, lock_d;
  logic             gnt_q, gnt_d;
  logic             err_q, err_d;

  logic             gnt, slot_free, acc;
  beat_w_t          acc_beat, out_beat;
  logic [BEAT_W-1:0] out_flat;

  // Ready depends only on registered state and io_out_ready, never on the valids.
  // That is why the IDLE grant is registered: a lone requester on the non-granted
  // port waits one cycle for gnt_q to swing to it.
  assign gnt           = (state_q == ST_LOCKED) ? lock_q : gnt_q;
  assign io_in_0_ready = reset & ~gnt & slot_free;
  assign io_in_1_ready = reset &  gnt & slot_free;
  assign acc           = (io_in_0_valid & io_in_0_ready) | (io_in_1_valid & io_in_1_ready);

  // Steer the granted port's beat toward the output register.
  always_comb begin
    acc_beat = gnt ? '{io_in_1_bits_id, io_in_1_bits_offset, io_in_1_bits_data}
                   : '{io_in_0_bits_id, io_in_0_bits_offset, io_in_0_bits_data};
  end

  // Burst sequencing: beat count, lock, round-robin pointer and the sticky offset error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    if (acc) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (acc_beat.offset != 3'(cnt_q)) err_d = 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        rr_d    = ~gnt;
        gnt_d   = pick_port(io_in_0_valid, io_in_1_valid, ~gnt, gnt);
      end else if (state_q == ST_IDLE) begin
        state_d = ST_LOCKED;
        lock_d  = gnt;
      end
    end else if (state_q == ST_IDLE) begin
      gnt_d = pick_port(io_in_0_valid, io_in_1_valid, rr_q, gnt_q);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      lock_q  <= 1'b0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  beat_out_slice #(.W(BEAT_W)) u_out (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (acc),
    .in_data   (acc_beat),
    .in_src    (gnt),
    .out_ready (io_out_ready),
    .out_valid (io_out_valid),
    .out_data  (out_flat),
    .out_src   (io_out_bits_src),
    .slot_free (slot_free)
  );

  assign out_beat           = beat_w_t'(out_flat);
  assign io_out_bits_id     = out_beat.id;
  assign io_out_bits_offset = out_beat.offset;
  assign io_out_bits_data   = out_beat.data;
  assign io_err_offset      = err_q;

endmodule

// File: tb/tb_beat_burst_arbiter.sv
// Directed bench for beat_burst_arbiter; expected values are hand-derived per step.
module tb_beat_burst_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_0_valid = 1'b0, io_in_1_valid = 1'b0;
  logic        io_in_0_ready, io_in_1_ready;
  logic        io_in_0_bits_id = 1'b0, io_in_1_bits_id = 1'b1;
  logic [2:0]  io_in_0_bits_offset = '0, io_in_1_bits_offset = '0;
  logic [63:0] io_in_0_bits_data = '0, io_in_1_bits_data = '0;
  logic        io_out_ready = 1'b0;
  logic        io_out_valid, io_out_bits_id, io_out_bits_src, io_err_offset;
  logic [2:0]  io_out_bits_offset;
  logic [63:0] io_out_bits_data;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  beat_burst_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .io_in_0_valid       (io_in_0_valid),
    .io_in_0_ready       (io_in_0_ready),
    .io_in_0_bits_id     (io_in_0_bits_id),
    .io_in_0_bits_offset (io_in_0_bits_offset),
    .io_in_0_bits_data   (io_in_0_bits_data),
    .io_in_1_valid       (io_in_1_valid),
    .io_in_1_ready       (io_in_1_ready),
    .io_in_1_bits_id     (io_in_1_bits_id),
    .io_in_1_bits_offset (io_in_1_bits_offset),
    .io_in_1_bits_data   (io_in_1_bits_data),
    .io_out_ready        (io_out_ready),
    .io_out_valid        (io_out_valid),
    .io_out_bits_id      (io_out_bits_id),
    .io_out_bits_offset  (io_out_bits_offset),
    .io_out_bits_data    (io_out_bits_data),
    .io_out_bits_src     (io_out_bits_src),
    .io_err_offset       (io_err_offset)
  );

  function automatic logic [63:0] d0(input int k);
    return 64'hA5A5_0000_0000_0000 | 64'(k);
  endfunction

  function automatic logic [63:0] d1(input int k);
    return 64'h5A5A_0000_0000_0100 | 64'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic id, input int off,
                         input logic [63:0] data, input logic src);
    chk({tag, "_valid"},  64'(io_out_valid), 64'd1);
    chk({tag, "_id"},     64'(io_out_bits_id), 64'(id));
    chk({tag, "_offset"}, 64'(io_out_bits_offset), 64'(off));
    chk({tag, "_data"},   io_out_bits_data, data);
    chk({tag, "_src"},    64'(io_out_bits_src), 64'(src));
  endtask

  // Inputs change on the falling edge, so they are stable across each rising edge.
  task automatic drive(input logic v0, input int o0, input logic v1, input int o1,
                       input logic ordy);
    @(negedge clock);
    io_in_0_valid       = v0;
    io_in_0_bits_offset = 3'(o0);
    io_in_0_bits_data   = d0(o0);
    io_in_1_valid       = v1;
    io_in_1_bits_offset = 3'(o1);
    io_in_1_bits_data   = d1(o1);
    io_out_ready        = ordy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    io_in_0_valid = 1'b0;
    io_in_1_valid = 1'b0;
    io_out_ready  = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    @(negedge clock); #1;
    chk("rst_valid",  64'(io_out_valid), 64'd0);
    chk("rst_rdy0",   64'(io_in_0_ready), 64'd0);
    chk("rst_rdy1",   64'(io_in_1_ready), 64'd0);
    chk("rst_err",    64'(io_err_offset), 64'd0);
    chk("rst_offset", 64'(io_out_bits_offset), 64'd0);
    chk("rst_data",   io_out_bits_data, 64'd0);
    chk("rst_src",    64'(io_out_bits_src), 64'd0);
    reset = 1'b1;

    // Port 0 alone, offsets 0..7 back to back
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k, 1'b0, 0, 1'b1);
      chk($sformatf("solo_rdy0_%0d", k), 64'(io_in_0_ready), 64'd1);
      chk($sformatf("solo_rdy1_%0d", k), 64'(io_in_1_ready), 64'd0);
      if (k > 0) chk_out($sformatf("solo_out%0d", k - 1), 1'b0, k - 1, d0(k - 1), 1'b0);
    end
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk_out("solo_out7", 1'b0, 7, d0(7), 1'b0);
    chk("solo_err", 64'(io_err_offset), 64'd0);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk("solo_drain", 64'(io_out_valid), 64'd0);

    // Both valid from the first cycle: port 0 burst, then port 1 burst
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k, 1'b1, 0, 1'b1);
      chk($sformatf("both_rdy0_%0d", k), 64'(io_in_0_ready), 64'd1);
      chk($sformatf("both_rdy1_%0d", k), 64'(io_in_1_ready), 64'd0);
      if (k > 0) chk_out($sformatf("both_p0out%0d", k - 1), 1'b0, k - 1, d0(k - 1), 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      drive(1'b0, 0, 1'b1, j, 1'b1);
      chk($sformatf("both_p1rdy1_%0d", j), 64'(io_in_1_ready), 64'd1);
      chk($sformatf("both_p1rdy0_%0d", j), 64'(io_in_0_ready), 64'd0);
      if (j == 0) chk_out("both_p0out7", 1'b0, 7, d0(7), 1'b0);
      else        chk_out($sformatf("both_p1out%0d", j - 1), 1'b1, j - 1, d1(j - 1), 1'b1);
    end
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk_out("both_p1out7", 1'b1, 7, d1(7), 1'b1);
    chk("both_err", 64'(io_err_offset), 64'd0);

    // Port 1 arrives mid-burst at beat 3: no interleave
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k, (k >= 3), 0, 1'b1);
      chk($sformatf("mid_rdy0_%0d", k), 64'(io_in_0_ready), 64'd1);
      if (k >= 3) chk($sformatf("mid_rdy1_%0d", k), 64'(io_in_1_ready), 64'd0);
    end
    drive(1'b0, 0, 1'b1, 0, 1'b1);
    chk("mid_hand_rdy1", 64'(io_in_1_ready), 64'd1);
    chk("mid_hand_rdy0", 64'(io_in_0_ready), 64'd0);
    chk_out("mid_p0out7", 1'b0, 7, d0(7), 1'b0);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk_out("mid_p1out0", 1'b1, 0, d1(0), 1'b1);

    // Downstream stall for 5 cycles after beat 4
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k, 1'b0, 0, 1'b1);
      if (k > 0) chk_out($sformatf("stall_out%0d", k - 1), 1'b0, k - 1, d0(k - 1), 1'b0);
    end
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, 5, 1'b0, 0, 1'b0);
      chk($sformatf("stall_rdy0_%0d", s), 64'(io_in_0_ready), 64'd0);
      chk_out($sformatf("stall_hold%0d", s), 1'b0, 4, d0(4), 1'b0);
    end
    for (int k = 5; k < 8; k++) begin
      drive(1'b1, k, 1'b0, 0, 1'b1);
      chk($sformatf("stall_rdy0r_%0d", k), 64'(io_in_0_ready), 64'd1);
      chk_out($sformatf("stall_outr%0d", k - 1), 1'b0, k - 1, d0(k - 1), 1'b0);
    end
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk_out("stall_out7", 1'b0, 7, d0(7), 1'b0);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk("stall_drain", 64'(io_out_valid), 64'd0);

    // Offsets 0,1,3: the offset error is sticky
    do_reset();
    drive(1'b1, 0, 1'b0, 0, 1'b1);
    drive(1'b1, 1, 1'b0, 0, 1'b1);
    drive(1'b1, 3, 1'b0, 0, 1'b1);
    chk("err_before", 64'(io_err_offset), 64'd0);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk("err_rise", 64'(io_err_offset), 64'd1);
    chk_out("err_out3", 1'b0, 3, d0(3), 1'b0);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk("err_stay1", 64'(io_err_offset), 64'd1);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk("err_stay2", 64'(io_err_offset), 64'd1);

    // Continue the same burst to beat 5, then assert reset with the beat held
    drive(1'b1, 3, 1'b0, 0, 1'b1);
    drive(1'b1, 4, 1'b0, 0, 1'b1);
    drive(1'b1, 5, 1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk_out("rmid_out5", 1'b0, 5, d0(5), 1'b0);
    chk("rmid_err_pre", 64'(io_err_offset), 64'd1);
    reset = 1'b0;
    #1;
    chk("rmid_valid",  64'(io_out_valid), 64'd0);
    chk("rmid_offset", 64'(io_out_bits_offset), 64'd0);
    chk("rmid_data",   io_out_bits_data, 64'd0);
    chk("rmid_src",    64'(io_out_bits_src), 64'd0);
    chk("rmid_err",    64'(io_err_offset), 64'd0);
    chk("rmid_rdy0",   64'(io_in_0_ready), 64'd0);
    chk("rmid_rdy1",   64'(io_in_1_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k, 1'b0, 0, 1'b1);
      chk($sformatf("post_rdy0_%0d", k), 64'(io_in_0_ready), 64'd1);
      if (k > 0) chk_out($sformatf("post_out%0d", k - 1), 1'b0, k - 1, d0(k - 1), 1'b0);
    end
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    chk_out("post_out7", 1'b0, 7, d0(7), 1'b0);
    chk("post_err", 64'(io_err_offset), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beat_burst_arbiter.md
BEAT_BURST_ARBITER -- requirements
Module: beat_burst_arbiter

Interface
REQ-001 Parameter BEATS, default 8: beats per burst; power of two, 2..8.
REQ-002 Parameter DATA_W, default 64: beat data width.
REQ-003 clock  input  1  sole clock; all state rises on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 io_in_0_valid / io_in_1_valid  input  1  requester beat valid.
REQ-006 io_in_0_ready / io_in_1_ready  output  1  beat accepted this cycle when valid & ready.
REQ-007 io_in_N_bits_id  input  1  transaction id, per requester.
REQ-008 io_in_N_bits_offset  input  3  beat index within burst, per requester.
REQ-009 io_in_N_bits_data  input  DATA_W  beat payload, per requester.
REQ-010 io_out_ready  input  1  downstream accepts the output beat.
REQ-011 io_out_valid  output  1  registered output beat valid.
REQ-012 io_out_bits_id / _offset / _data  output  1 / 3 / DATA_W  registered copy of the accepted beat.
REQ-013 io_out_bits_src  output  1  index of the requester that supplied the output beat.
REQ-014 io_err_offset  output  1  sticky: an accepted beat had an offset different from the burst beat count.

Function
REQ-015 FSM states IDLE and LOCKED; the grant holds for a full burst of BEATS beats with no interleaving.
REQ-016 IDLE: when exactly one input is valid, grant it; when both are valid, grant the port selected by round-robin pointer rr.
REQ-017 Slot free = ~io_out_valid | io_out_ready; io_in_G_ready = granted & slot free; the ungranted ready = 0.
REQ-018 Accepted beat (valid & ready) loads the output register the same edge; input-to-output latency 1 cycle; full throughput of 1 beat/cycle under continuous io_out_ready.
REQ-019 Beat counter cnt (log2 BEATS bits) increments per accepted beat and wraps to 0 after BEATS-1.
REQ-020 Accepted beat with cnt=0 in IDLE and BEATS>1: go to LOCKED, lock = granted port.
REQ-021 LOCKED: only the lock port is granted, regardless of the other valid; an idle lock port stalls (no timeout).
REQ-022 Accepted beat with cnt=BEATS-1: go to IDLE, rr = ~lock, so the other port wins the next tie.
REQ-023 The output register holds its value while io_out_valid & ~io_out_ready; io_out_valid clears when the beat is taken and no new beat is accepted.
REQ-024 io_err_offset sets when an accepted beat's offset != cnt and stays set until reset; data still passes unmodified.
REQ-025 No combinational path from io_in_*_valid to io_in_*_ready; the ready path depends only on state and io_out_ready.

Reset
REQ-026 Reset asserted: state IDLE, cnt 0, rr 0 (port 0 favoured), lock 0, io_out_valid 0, io_out_bits_* 0, io_out_bits_src 0, io_err_offset 0, both in_ready 0.
REQ-027 Reset mid-burst discards the partial burst and the held output beat; the first post-reset burst arbitrates fresh from IDLE.

Structure
REQ-028 A shared package holds the state enum (IDLE, LOCKED), the beat struct {id, offset[2:0], data}, and the BEATS/DATA_W defaults.
REQ-029 One sub-module, beat_out_slice: a single-entry valid/ready register for the beat struct plus src.

Verification
REQ-030 Port 0 alone sends 8 beats, offsets 0..7, io_out_ready=1 -> out beats offsets 0..7 on consecutive cycles, 1-cycle latency, src=0, err=0.
REQ-031 Both valid from cycle 0 after reset -> port 0 burst of 8 completes uninterrupted, then port 1 burst of 8; io_in_1_ready=0 throughout the port-0 burst.
REQ-032 Port 1 raises valid mid port-0 burst at beat 3 -> no interleave; port 1 granted on the cycle after port-0 beat 7 is accepted.
REQ-033 io_out_ready low for 5 cycles at beat 4 -> output holds beat 4 stable, in_ready=0, no beat lost or duplicated.
REQ-034 Port 0 sends offsets 0,1,3 -> io_err_offset rises the cycle after offset 3 is accepted and stays 1.
REQ-035 Reset asserted after beat 5 of a burst -> all outputs 0 immediately; the next burst starts at cnt 0 with err 0.
